// File: rtl/pwm_multi_dimmer.sv
// Multi-channel PWM dimmer: shared prescaler and counter, per-channel double-buffered duty.
// Optional macro PWM_FADE_EN ramps each active duty one count per period toward its loaded target.
module pwm_multi_dimmer #(
  parameter int CHANNELS   = 4,
  parameter int RES        = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHANNELS*RES-1:0] duty,
  input  logic                    load,
  input  logic [PRESCALE_W-1:0]   prescale,
  output logic [CHANNELS-1:0]     out,
  output logic                    period_tick
);

  localparam logic [RES-1:0]        CNT_ONE  = {{(RES-1){1'b0}}, 1'b1};
  localparam logic [RES-1:0]        CNT_MAX  = {RES{1'b1}};
  localparam logic [RES-1:0]        CNT_ZERO = {RES{1'b0}};
  localparam logic [PRESCALE_W-1:0] PRE_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};

  logic [CHANNELS-1:0][RES-1:0] duty_s;
  logic [PRESCALE_W-1:0]        pre_cnt_r;
  logic [PRESCALE_W-1:0]        pre_cnt_nxt_s;
  logic [RES-1:0]               pwm_cnt_r;
  logic [RES-1:0]               pwm_cnt_nxt_s;
  logic [CHANNELS-1:0][RES-1:0] act_r;
  logic [CHANNELS-1:0][RES-1:0] act_nxt_s;
  logic [CHANNELS-1:0][RES-1:0] shadow_r;
  logic [CHANNELS-1:0]          out_r;
  logic [CHANNELS-1:0]          out_nxt_s;
  logic                         period_tick_r;
  logic                         step_s;
  logic                         wrap_s;
`ifndef PWM_FADE_EN
  logic                         pending_r;
  logic                         pending_nxt_s;
`endif

  assign duty_s      = duty;
  assign out         = out_r;
  assign period_tick = period_tick_r;

  // Prescaler and period counter; >= lets a shrinking prescale take effect immediately
  always_comb begin
    step_s = (pre_cnt_r >= prescale);
    wrap_s = step_s && (pwm_cnt_r == CNT_MAX);
    if (step_s) begin
      pre_cnt_nxt_s = PRE_ZERO;
      pwm_cnt_nxt_s = pwm_cnt_r + CNT_ONE;
    end else begin
      pre_cnt_nxt_s = pre_cnt_r + PRE_ONE;
      pwm_cnt_nxt_s = pwm_cnt_r;
    end
  end

  // Active duty only moves on the wrap edge, so a period is never cut short
  always_comb begin
    act_nxt_s = act_r;
    out_nxt_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      out_nxt_s[i] = (pwm_cnt_r < act_r[i]);
`ifdef PWM_FADE_EN
      if (!wrap_s) begin
        act_nxt_s[i] = act_r[i];
      end else if (act_r[i] < shadow_r[i]) begin
        act_nxt_s[i] = act_r[i] + CNT_ONE;
      end else if (act_r[i] > shadow_r[i]) begin
        act_nxt_s[i] = act_r[i] - CNT_ONE;
      end else begin
        act_nxt_s[i] = act_r[i];
      end
`else
      if (wrap_s && load) begin
        act_nxt_s[i] = duty_s[i];
      end else if (wrap_s && pending_r) begin
        act_nxt_s[i] = shadow_r[i];
      end else begin
        act_nxt_s[i] = act_r[i];
      end
`endif
    end
  end

`ifndef PWM_FADE_EN
  // A load coinciding with the wrap is consumed by the bypass, so the wrap always clears pending
  always_comb begin
    if (wrap_s) begin
      pending_nxt_s = 1'b0;
    end else if (load) begin
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end
  end
`endif

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_r     <= PRE_ZERO;
      pwm_cnt_r     <= CNT_ZERO;
      act_r         <= {CHANNELS{CNT_ZERO}};
      shadow_r      <= {CHANNELS{CNT_ZERO}};
      out_r         <= {CHANNELS{1'b0}};
      period_tick_r <= 1'b0;
`ifndef PWM_FADE_EN
      pending_r     <= 1'b0;
`endif
    end else begin
      pre_cnt_r     <= pre_cnt_nxt_s;
      pwm_cnt_r     <= pwm_cnt_nxt_s;
      act_r         <= act_nxt_s;
      out_r         <= out_nxt_s;
      period_tick_r <= wrap_s;
      if (load) begin
        shadow_r <= duty_s;
      end
`ifndef PWM_FADE_EN
      pending_r     <= pending_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_pwm_multi_dimmer.sv
// Self-checking bench for pwm_multi_dimmer: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model and per-period high counts.
module tb_pwm_multi_dimmer;
  localparam int CH     = 4;
  localparam int RES    = 8;
  localparam int PW     = 16;
  localparam int PERIOD = 1 << RES;

  logic              clk = 1'b0;
  logic              rst;
  logic              load;
  logic [CH*RES-1:0] duty;
  logic [PW-1:0]     prescale;
  logic [CH-1:0]     out;
  logic              period_tick;

  int n_assert = 0;
  int n_fail   = 0;

  // behavioural model state
  int            m_pre, m_cnt, m_pend;
  int            m_act[CH];
  int            m_tgt[CH];
  logic [CH-1:0] m_out;
  logic          m_tick;

  // observation window accumulators
  int w_hi[CH];
  int w_run[CH];
  int w_cur[CH];
  int w_len, w_mm, w_tick;

  pwm_multi_dimmer #(.CHANNELS(CH), .RES(RES), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .duty(duty), .load(load),
    .prescale(prescale), .out(out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  function automatic int duty_of(input int i);
    return int'(duty[i*RES +: RES]);
  endfunction

  task automatic set_duty(input int ch, input int v);
    duty[ch*RES +: RES] = RES'(v);
  endtask

  // advance model and DUT by one clock, then observe DUT against the model
  task automatic tick_clk();
    bit            st, wr;
    logic [CH-1:0] nout;
    st = (m_pre >= int'(prescale));
    wr = st && (m_cnt == PERIOD - 1);
    for (int i = 0; i < CH; i++) nout[i] = (m_cnt < m_act[i]);
    if (rst) begin
      m_pre = 0; m_cnt = 0; m_pend = 0; m_out = '0; m_tick = 1'b0;
      for (int i = 0; i < CH; i++) begin m_act[i] = 0; m_tgt[i] = 0; end
    end else begin
      m_out  = nout;
      m_tick = wr;
      m_pre  = st ? 0 : m_pre + 1;
      if (st) m_cnt = (m_cnt + 1) % PERIOD;
      if (wr) begin
        for (int i = 0; i < CH; i++) begin
`ifdef PWM_FADE_EN
          if (m_act[i] < m_tgt[i]) m_act[i] = m_act[i] + 1;
          else if (m_act[i] > m_tgt[i]) m_act[i] = m_act[i] - 1;
`else
          if (load) m_act[i] = duty_of(i);
          else if (m_pend != 0) m_act[i] = m_tgt[i];
`endif
        end
      end
      if (load) for (int i = 0; i < CH; i++) m_tgt[i] = duty_of(i);
      m_pend = wr ? 0 : (load ? 1 : m_pend);
    end
    @(posedge clk);
    #1;
    w_len++;
    if (out !== m_out || period_tick !== m_tick) w_mm++;
    for (int i = 0; i < CH; i++) begin
      if (out[i] === 1'b1) begin
        w_hi[i]++; w_cur[i]++;
        if (w_cur[i] > w_run[i]) w_run[i] = w_cur[i];
      end else begin
        w_cur[i] = 0;
      end
    end
    if (period_tick === 1'b1) w_tick++;
  endtask

  task automatic clear_window();
    for (int i = 0; i < CH; i++) begin w_hi[i] = 0; w_run[i] = 0; w_cur[i] = 0; end
    w_len = 0; w_mm = 0; w_tick = 0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) tick_clk();
  endtask

  task automatic run_to_tick(input int maxc);
    int n;
    n = 0;
    do begin
      tick_clk();
      n++;
    end while (period_tick !== 1'b1 && n < maxc);
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick_clk();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; prescale = '0; duty = '0;
    m_out = '0; m_tick = 1'b0;
    clear_window();
    run_cycles(3);
    rst = 1'b0;
    n_assert++; if (out !== {CH{1'b0}}) begin n_fail++; $display("FAIL reset_out: got %b expected %b", out, {CH{1'b0}}); end
    n_assert++; if (period_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", period_tick); end
    n_assert++; if (w_mm != 0) begin n_fail++; $display("FAIL reset_model: %0d cycle mismatches expected 0", w_mm); end
  endtask

  task automatic test_hold();
    int exp_d[CH] = '{0, 64, 128, 255};
    prescale = '0;
    for (int i = 0; i < CH; i++) set_duty(i, exp_d[i]);
    clear_window();
    pulse_load();
    run_to_tick(600);
    for (int i = 0; i < CH; i++) begin
      n_assert++; if (w_hi[i] != 0) begin n_fail++; $display("FAIL hold_prewrap ch%0d: got %0d high expected 0", i, w_hi[i]); end
    end
    n_assert++; if (w_tick != 1) begin n_fail++; $display("FAIL hold_first_tick: got %0d ticks expected 1", w_tick); end
    for (int w = 0; w < 2; w++) begin
      clear_window();
      run_to_tick(600);
      n_assert++; if (w_len != PERIOD) begin n_fail++; $display("FAIL hold_period: got %0d clocks expected %0d", w_len, PERIOD); end
      for (int i = 0; i < CH; i++) begin
        n_assert++; if (w_hi[i] != exp_d[i]) begin n_fail++; $display("FAIL hold_high ch%0d: got %0d expected %0d", i, w_hi[i], exp_d[i]); end
      end
      n_assert++; if (w_mm != 0) begin n_fail++; $display("FAIL hold_model: %0d mismatches expected 0", w_mm); end
    end
  endtask

  task automatic test_prescale();
    int c, exp_len, n;
    prescale = 16'd3;
    set_duty(0, 128);
    for (int i = 1; i < CH; i++) set_duty(i, $urandom_range(0, PERIOD - 1));
    pulse_load();
    run_to_tick(5000);
    clear_window();
    run_to_tick(5000);
    n_assert++; if (w_len != 4 * PERIOD) begin n_fail++; $display("FAIL pre_period: got %0d clocks expected %0d", w_len, 4 * PERIOD); end
    n_assert++; if (w_hi[0] != 512) begin n_fail++; $display("FAIL pre_high: got %0d expected 512", w_hi[0]); end
    n_assert++; if (w_run[0] != 512) begin n_fail++; $display("FAIL pre_run: got %0d consecutive expected 512", w_run[0]); end
    n_assert++; if (w_mm != 0) begin n_fail++; $display("FAIL pre_model: %0d mismatches expected 0", w_mm); end
    n = 0;
    while (m_pre != 3 && n < 10) begin tick_clk(); n++; end
    c = m_cnt;
    prescale = 16'd1;
    exp_len = 1 + 2 * (PERIOD - 1 - c);
    clear_window();
    run_to_tick(3000);
    n_assert++; if (w_len != exp_len) begin n_fail++; $display("FAIL pre_change_wrap: got %0d clocks expected %0d", w_len, exp_len); end
    clear_window();
    run_to_tick(3000);
    n_assert++; if (w_len != 2 * PERIOD) begin n_fail++; $display("FAIL pre_change_period: got %0d clocks expected %0d", w_len, 2 * PERIOD); end
    n_assert++; if (w_mm != 0) begin n_fail++; $display("FAIL pre_change_model: %0d mismatches expected 0", w_mm); end
  endtask

  task automatic test_double_buffer();
    prescale = '0;
    run_to_tick(3000);
    set_duty(0, 50);
    pulse_load();
    run_to_tick(600);
    clear_window();
    run_cycles(100);
    set_duty(0, 200);
    pulse_load();
    run_to_tick(600);
    n_assert++; if (w_hi[0] != 50) begin n_fail++; $display("FAIL dbuf_keep: got %0d expected 50", w_hi[0]); end
    n_assert++; if (w_len != PERIOD) begin n_fail++; $display("FAIL dbuf_len: got %0d expected %0d", w_len, PERIOD); end
    clear_window();
    run_to_tick(600);
    n_assert++; if (w_hi[0] != 200) begin n_fail++; $display("FAIL dbuf_apply: got %0d expected 200", w_hi[0]); end
    clear_window();
    run_cycles(100);
    set_duty(0, 120);
    pulse_load();
    run_cycles(50);
    set_duty(0, 10);
    pulse_load();
    run_to_tick(600);
    n_assert++; if (w_hi[0] != 200) begin n_fail++; $display("FAIL dbuf_keep2: got %0d expected 200", w_hi[0]); end
    clear_window();
    run_to_tick(600);
    n_assert++; if (w_hi[0] != 10) begin n_fail++; $display("FAIL dbuf_last_wins: got %0d expected 10", w_hi[0]); end
    n_assert++; if (w_mm != 0) begin n_fail++; $display("FAIL dbuf_model: %0d mismatches expected 0", w_mm); end
  endtask

  task automatic test_load_at_wrap();
    clear_window();
    run_cycles(PERIOD - 1);
    set_duty(0, 30);
    pulse_load();
    n_assert++; if (period_tick !== 1'b1) begin n_fail++; $display("FAIL lwrap_tick: got %b expected 1", period_tick); end
    n_assert++; if (w_len != PERIOD) begin n_fail++; $display("FAIL lwrap_len: got %0d expected %0d", w_len, PERIOD); end
    clear_window();
    run_to_tick(600);
    n_assert++; if (w_hi[0] != 30) begin n_fail++; $display("FAIL lwrap_bypass: got %0d expected 30", w_hi[0]); end
    n_assert++; if (w_mm != 0) begin n_fail++; $display("FAIL lwrap_model: %0d mismatches expected 0", w_mm); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < CH; i++) set_duty(i, $urandom_range(1, PERIOD - 1));
    set_duty(0, 99);
    clear_window();
    run_cycles(10);
    pulse_load();
    run_cycles(66);
    rst = 1'b1;
    tick_clk();
    rst = 1'b0;
    n_assert++; if (out !== {CH{1'b0}}) begin n_fail++; $display("FAIL rmid_out: got %b expected 0", out); end
    n_assert++; if (period_tick !== 1'b0) begin n_fail++; $display("FAIL rmid_tick: got %b expected 0", period_tick); end
    clear_window();
    run_to_tick(600);
    n_assert++; if (w_len != PERIOD) begin n_fail++; $display("FAIL rmid_restart: got %0d clocks expected %0d", w_len, PERIOD); end
    clear_window();
    run_to_tick(600);
    for (int i = 0; i < CH; i++) begin
      n_assert++; if (w_hi[i] != 0) begin n_fail++; $display("FAIL rmid_discard ch%0d: got %0d expected 0", i, w_hi[i]); end
    end
    n_assert++; if (w_mm != 0) begin n_fail++; $display("FAIL rmid_model: %0d mismatches expected 0", w_mm); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      prescale = PW'($urandom_range(0, 2));
      clear_window();
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 63) == 0) begin
          for (int i = 0; i < CH; i++) set_duty(i, $urandom_range(0, PERIOD - 1));
          load = 1'b1;
        end else begin
          load = 1'b0;
        end
        if ($urandom_range(0, 255) == 0) prescale = PW'($urandom_range(0, 3));
        rst = ($urandom_range(0, 999) == 0);
        tick_clk();
      end
      load = 1'b0; rst = 1'b0;
      n_assert++; if (w_mm != 0) begin n_fail++; $display("FAIL random_model iter%0d: %0d mismatches expected 0", it, w_mm); end
    end
  endtask

`ifdef PWM_FADE_EN
  task automatic test_fade();
    int exp_h;
    prescale = '0;
    rst = 1'b1; tick_clk(); rst = 1'b0;
    set_duty(0, 5);
    pulse_load();
    run_to_tick(600);
    for (int k = 1; k <= 7; k++) begin
      exp_h = (k < 5) ? k : 5;
      clear_window();
      run_to_tick(600);
      n_assert++; if (w_hi[0] != exp_h) begin n_fail++; $display("FAIL fade_up step%0d: got %0d expected %0d", k, w_hi[0], exp_h); end
    end
    clear_window();
    set_duty(0, 3);
    pulse_load();
    run_to_tick(600);
    n_assert++; if (w_hi[0] != 5) begin n_fail++; $display("FAIL fade_hold: got %0d expected 5", w_hi[0]); end
    clear_window();
    run_to_tick(600);
    n_assert++; if (w_hi[0] != 4) begin n_fail++; $display("FAIL fade_down1: got %0d expected 4", w_hi[0]); end
    clear_window();
    run_to_tick(600);
    n_assert++; if (w_hi[0] != 3) begin n_fail++; $display("FAIL fade_down2: got %0d expected 3", w_hi[0]); end
    n_assert++; if (w_mm != 0) begin n_fail++; $display("FAIL fade_model: %0d mismatches expected 0", w_mm); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PWM_FADE_EN
    test_fade();
`else
    test_hold();
    test_prescale();
    test_double_buffer();
    test_load_at_wrap();
    test_reset_mid();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi_dimmer.md
# pwm_multi_dimmer

Multi-channel PWM dimmer for LED banks; next generation of the single-channel 4-bit dimmer. It adds configurable channel count and resolution, a programmable clock prescaler and glitch-free double-buffered duty updates. An optional fade mode ramps duty linearly. It sits between the register/control logic (duty values, load strobe) and the LED output pins.

## Interface
- `CHANNELS`, 4, number of independent PWM outputs (1..16)
- `RES`, 8, counter/duty resolution in bits (2..12); period = 2^RES counter steps
- `PRESCALE_W`, 16, width of prescale input
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `duty`  in  CHANNELS*RES  packed duty values; channel i at bits [i*RES +: RES]
- `load`  in  1  one-cycle strobe: capture `duty` into shadow registers
- `prescale`  in  PRESCALE_W  counter advances once every prescale+1 clocks
- `out`  out  CHANNELS  registered PWM outputs
- `period_tick`  out  1  one-cycle pulse at every PWM period wrap

## Operation
- Prescaler: `pre_cnt` counts 0..`prescale`. `step` = (`pre_cnt` >= `prescale`), and `pre_cnt` then returns to 0. Using >= means a live decrease of `prescale` below `pre_cnt` takes effect next cycle with no long stall. `prescale`=0 gives `step` every cycle.
- Counter: `pwm_cnt` (RES bits) increments on `step` and wraps 2^RES-1 -> 0. `wrap` = `step` && `pwm_cnt`==2^RES-1.
- Shadow: `load` captures all channels of `duty` into `shadow[i]` and sets `pending`. A later `load` before the wrap overwrites the shadow; the last value wins.
- Active duty update, non-fade, on the `wrap` edge only:
  - if `load` is high in the same cycle, `act[i]` <= `duty[i]` (bypass);
  - else if `pending`, `act[i]` <= `shadow[i]`;
  - `pending` clears.
  - Duty never changes mid-period, so there are no runt pulses.
- Output: each cycle, `out[i]` <= (`pwm_cnt` < `act[i]`).
  - `act`=0 gives constantly low.
  - `act`=2^RES-1 gives high for 2^RES-1 of 2^RES steps. Full-on is not supported.
- `period_tick` <= `wrap`.

## Timing
- Reset values: `pre_cnt`=0, `pwm_cnt`=0, `act`=0, `shadow`=0, `pending`=0, `out`=0, `period_tick`=0.
- First step after reset: `pwm_cnt`=0 is held for `prescale`+1 clocks.
- `out` lags `pwm_cnt` by one clock.
- `period_tick` is high during the clock after the `wrap` edge. That is the same cycle in which `pwm_cnt` first reads 0 and `out` still reflects count 2^RES-1.
- Latency from `load` to a visible output change: duty is applied at the next `wrap`. `out` reflects it one clock later.
- `rst` asserted mid-period: all state returns to reset values on that edge. Any pending shadow is discarded.
- `prescale` change: takes effect on the next `pre_cnt` comparison. `pwm_cnt` is unaffected.

## Configuration
- `PWM_FADE_EN` defined:
  - `shadow[i]` acts as a persistent target; `pending` is unused.
  - On each `wrap`, `act[i]` moves one count toward the target: +1 if below, -1 if above, no change if equal.
  - `load` in the wrap cycle updates the target only. The step that cycle uses the old target.
  - Full-scale ramp from 0 to 2^RES-1 takes 2^RES-1 periods.
- `PWM_FADE_EN` undefined: immediate double-buffered update as above. No fade logic is synthesised.

## Test plan
- Reset, then hold: CHANNELS=4, RES=8, `prescale`=0, `duty` ch0..3 = 0/64/128/255, pulse `load`.
  - Before the first wrap, `out`=0.
  - After it: per period, ch0 high 0 clocks, ch1 64, ch2 128, ch3 255.
  - `period_tick` every 256 clocks.
- Prescale: `prescale`=3, ch0=128.
  - Period = 1024 clocks; ch0 high 512 consecutive clocks.
  - Change `prescale` to 1 while `pre_cnt`=3: the next step occurs one clock later, then every 2 clocks.
- Double buffer: `load` ch0=200 at `pwm_cnt`=100 while `act`=50.
  - Current period keeps 50 high counts; the next period has 200.
  - A second `load` of 10 before the wrap: the next period has 10.
- Load at wrap: `load` ch0=30 in the cycle `wrap` is true.
  - The period starting immediately has 30 high counts.
- Reset mid-operation: assert `rst` at `pwm_cnt`=77 with `pending` set.
  - Next cycle: all outputs 0, `pwm_cnt`=0.
  - The pending value is never applied.
- Fade (`PWM_FADE_EN`): `act`=0, load target 5.
  - `act` reads 1,2,3,4,5 after successive wraps, then holds.
  - Load target 3: `act` reads 4 then 3 over two wraps.
